// File: rtl/mips_multicycle_control_pkg.sv
// Shared constants for the multicycle MIPS main control FSM.
// Holds the state encoding, opcode/funct codes and datapath select encodings.
// Combinational content only; no latency or backpressure of its own.
package mips_multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWR    = 4'd6,
    S_EXEC     = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_ADDIEX   = 4'd10,
    S_ADDIWB   = 4'd11,
    S_INTFETCH = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Bundle between the control FSM and the datapath: instruction fields in, strobes out.
// Pure wiring, zero latency.
// No backpressure; every strobe is a single-cycle command.
interface mips_multicycle_control_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       irq;
  logic [1:0] aluControl;
  logic [1:0] aluSrcB;
  logic       ALUSrcA;
  logic       PCSource;
  logic       PCWrite;
  logic       isBranch;
  logic       lorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       isInterrupted;
  logic       irqAck;
  logic       illegalOp;

  // Control side: reads instruction fields, drives strobes.
  modport master (
    input  op, funct, irq,
    output aluControl, aluSrcB, ALUSrcA, PCSource, PCWrite, isBranch, lorD,
           MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, isInterrupted,
           irqAck, illegalOp
  );

  // Datapath side: supplies instruction fields, consumes strobes.
  modport slave (
    output op, funct, irq,
    input  aluControl, aluSrcB, ALUSrcA, PCSource, PCWrite, isBranch, lorD,
           MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, isInterrupted,
           irqAck, illegalOp
  );
endinterface

// File: rtl/mips_multicycle_control_alu_decoder.sv
// R-type funct field to ALU operation, with a flag for supported functs.
// Purely combinational, zero latency.
// No backpressure.
module alu_decoder
  import mips_multicycle_control_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [1:0] alu_ctrl_o,
  output logic       valid_o
);

  // Map the four supported functs; anything else reads as add and invalid.
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    valid_o    = 1'b1;
    case (funct_i)
      FUNCT_ADD: alu_ctrl_o = ALU_ADD;
      FUNCT_SUB: alu_ctrl_o = ALU_SUB;
      FUNCT_AND: alu_ctrl_o = ALU_AND;
      FUNCT_OR:  alu_ctrl_o = ALU_OR;
      default:   valid_o    = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Moore main-control FSM for the multicycle MIPS core; optional IRQ fetch redirect via CONTROL_INTERRUPT_EN.
// One state per clock: lw 5, sw/R-type/addi 4, beq 3, illegal 2 cycles.
// No backpressure; memory is single-cycle and strobes are one-cycle pulses.
module mips_multicycle_control
  import mips_multicycle_control_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  mips_multicycle_control_if.master     bus
);

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       is_sw_q, is_sw_d;
  logic [1:0] dec_alu;
  logic       dec_valid;
  logic       int_taken;

  alu_decoder u_alu_decoder (
    .funct_i   (bus.funct),
    .alu_ctrl_o(dec_alu),
    .valid_o   (dec_valid)
  );

`ifdef CONTROL_INTERRUPT_EN
  logic irq_q;
  logic pending_q, pending_d;

  // A fresh irq edge sets the flag; leaving INTFETCH consumes it.
  always_comb begin
    pending_d = (pending_q && (state_q != S_INTFETCH)) || (bus.irq && !irq_q);
  end

  // Edge-detect register and pending flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      irq_q     <= bus.irq;
      pending_q <= pending_d;
    end
  end

  assign int_taken = pending_q;
`else
  assign int_taken = 1'b0;
`endif

  // Next-state logic; lw/sw choice is captured in DECODE so MEMADR need not look at op.
  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    is_sw_d   = is_sw_q;
    case (state_q)
      S_RESET:              state_d = S_FETCH;
      S_FETCH, S_INTFETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW:   begin state_d = S_MEMADR; is_sw_d = 1'b0; end
          OP_SW:   begin state_d = S_MEMADR; is_sw_d = 1'b1; end
          OP_BEQ:  state_d = S_BRANCH;
          OP_ADDI: state_d = S_ADDIEX;
          OP_RTYPE: begin
            if (dec_valid) begin
              state_d = S_EXEC;
            end else begin
              state_d   = S_FETCH;
              illegal_d = 1'b1;
            end
          end
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = is_sw_q ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB: state_d = S_FETCH;
      default:  state_d = S_RESET;
    endcase
    // Interrupts only redirect instruction boundaries, never mid-instruction.
    if (state_d == S_FETCH && int_taken) begin
      state_d = S_INTFETCH;
    end
  end

  // State and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      illegal_q <= 1'b0;
      is_sw_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      is_sw_q   <= is_sw_d;
    end
  end

  // Moore output decode; everything defaults low.
  always_comb begin
    bus.aluControl    = ALU_ADD;
    bus.aluSrcB       = SRCB_REG;
    bus.ALUSrcA       = 1'b0;
    bus.PCSource      = 1'b0;
    bus.PCWrite       = 1'b0;
    bus.isBranch      = 1'b0;
    bus.lorD          = 1'b0;
    bus.MemWrite      = 1'b0;
    bus.IRWrite       = 1'b0;
    bus.RegDst        = 1'b0;
    bus.MemtoReg      = 1'b0;
    bus.RegWrite      = 1'b0;
    bus.isInterrupted = 1'b0;
    bus.irqAck        = 1'b0;
    bus.illegalOp     = illegal_q;
    case (state_q)
      S_FETCH, S_INTFETCH: begin
        bus.IRWrite = 1'b1;
        bus.aluSrcB = SRCB_FOUR;
        bus.PCWrite = 1'b1;
        if (state_q == S_INTFETCH) begin
          bus.isInterrupted = 1'b1;
          bus.irqAck        = 1'b1;
        end
      end
      S_DECODE: bus.aluSrcB = SRCB_IMM_SH2;
      S_MEMADR, S_ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.aluSrcB = SRCB_IMM;
      end
      S_MEMRD: bus.lorD = 1'b1;
      S_MEMWB: begin
        bus.MemtoReg = 1'b1;
        bus.RegWrite = 1'b1;
      end
      S_MEMWR: begin
        bus.lorD     = 1'b1;
        bus.MemWrite = 1'b1;
      end
      S_EXEC: begin
        bus.ALUSrcA    = 1'b1;
        bus.aluControl = dec_alu;
      end
      S_ALUWB: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA    = 1'b1;
        bus.aluControl = ALU_SUB;
        bus.PCSource   = 1'b1;
        bus.isBranch   = 1'b1;
      end
      S_ADDIWB: bus.RegWrite = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for the multicycle MIPS control FSM.
// Each instruction pushes its expected per-cycle strobe vector; a negedge monitor pops and compares.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_mips_multicycle_control;

  typedef struct packed {
    logic [1:0] alu;
    logic [1:0] srcb;
    logic       srca;
    logic       pcsrc;
    logic       pcwr;
    logic       br;
    logic       lord;
    logic       memwr;
    logic       irwr;
    logic       regdst;
    logic       memtoreg;
    logic       regwr;
    logic       intr;
    logic       ack;
    logic       ill;
  } ctl_t;

  localparam int E_ZERO = 0, E_FETCH = 1, E_DECODE = 2, E_MEMADR = 3, E_MEMRD = 4,
                 E_MEMWB = 5, E_MEMWR = 6, E_EXEC = 7, E_ALUWB = 8, E_BRANCH = 9,
                 E_ADDIEX = 10, E_ADDIWB = 11, E_INTFETCH = 12;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mips_multicycle_control_if bus();

  mips_multicycle_control dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  ctl_t q_exp[$];
  string q_tag[$];
  ctl_t act;

  assign act = {bus.aluControl, bus.aluSrcB, bus.ALUSrcA, bus.PCSource, bus.PCWrite,
                bus.isBranch, bus.lorD, bus.MemWrite, bus.IRWrite, bus.RegDst,
                bus.MemtoReg, bus.RegWrite, bus.isInterrupted, bus.irqAck, bus.illegalOp};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %05h expected %05h", tag, got, want);
    end
  endtask

  // Expected strobes per state, straight from the state/output table.
  function automatic ctl_t expv(input int s, input logic [1:0] alu, input logic ill);
    ctl_t c;
    c = '0;
    case (s)
      E_FETCH, E_INTFETCH: begin
        c.srcb = 2'b01; c.pcwr = 1'b1; c.irwr = 1'b1; c.ill = ill;
        if (s == E_INTFETCH) begin c.intr = 1'b1; c.ack = 1'b1; end
      end
      E_DECODE: c.srcb = 2'b11;
      E_MEMADR, E_ADDIEX: begin c.srca = 1'b1; c.srcb = 2'b10; end
      E_MEMRD:  c.lord = 1'b1;
      E_MEMWB:  begin c.memtoreg = 1'b1; c.regwr = 1'b1; end
      E_MEMWR:  begin c.lord = 1'b1; c.memwr = 1'b1; end
      E_EXEC:   begin c.srca = 1'b1; c.alu = alu; end
      E_ALUWB:  begin c.regdst = 1'b1; c.regwr = 1'b1; end
      E_BRANCH: begin c.srca = 1'b1; c.alu = 2'b01; c.pcsrc = 1'b1; c.br = 1'b1; end
      E_ADDIWB: c.regwr = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  // Advance one clock and record what the DUT must show for that cycle.
  task automatic cyc(input int s, input logic [1:0] alu, input logic ill, input string tag);
    @(posedge clk);
    #1;
    q_exp.push_back(expv(s, alu, ill));
    q_tag.push_back(tag);
  endtask

  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      ctl_t  e;
      string t;
      e = q_exp.pop_front();
      t = q_tag.pop_front();
      check(t, 32'(act), 32'(e));
    end
  end

  task automatic run_lw();
    bus.op = 6'h23;
    cyc(E_DECODE, 2'b00, 1'b0, "lw_decode");
    cyc(E_MEMADR, 2'b00, 1'b0, "lw_memadr");
    cyc(E_MEMRD,  2'b00, 1'b0, "lw_memrd");
    cyc(E_MEMWB,  2'b00, 1'b0, "lw_memwb");
    cyc(E_FETCH,  2'b00, 1'b0, "lw_fetch");
  endtask

  task automatic run_sw();
    bus.op = 6'h2B;
    cyc(E_DECODE, 2'b00, 1'b0, "sw_decode");
    cyc(E_MEMADR, 2'b00, 1'b0, "sw_memadr");
    cyc(E_MEMWR,  2'b00, 1'b0, "sw_memwr");
    cyc(E_FETCH,  2'b00, 1'b0, "sw_fetch");
  endtask

  task automatic run_rtype(input logic [5:0] f, input logic [1:0] alu);
    bus.op = 6'h00; bus.funct = f;
    cyc(E_DECODE, 2'b00, 1'b0, "r_decode");
    cyc(E_EXEC,   alu,   1'b0, "r_exec");
    cyc(E_ALUWB,  2'b00, 1'b0, "r_aluwb");
    cyc(E_FETCH,  2'b00, 1'b0, "r_fetch");
  endtask

  task automatic run_beq();
    bus.op = 6'h04;
    cyc(E_DECODE, 2'b00, 1'b0, "beq_decode");
    cyc(E_BRANCH, 2'b00, 1'b0, "beq_branch");
    cyc(E_FETCH,  2'b00, 1'b0, "beq_fetch");
  endtask

  task automatic run_addi();
    bus.op = 6'h08;
    cyc(E_DECODE, 2'b00, 1'b0, "addi_decode");
    cyc(E_ADDIEX, 2'b00, 1'b0, "addi_ex");
    cyc(E_ADDIWB, 2'b00, 1'b0, "addi_wb");
    cyc(E_FETCH,  2'b00, 1'b0, "addi_fetch");
  endtask

  task automatic run_illegal(input logic [5:0] o, input logic [5:0] f);
    bus.op = o; bus.funct = f;
    cyc(E_DECODE, 2'b00, 1'b0, "ill_decode");
    cyc(E_FETCH,  2'b00, 1'b1, "ill_fetch");
  endtask

  logic [5:0] fn_tab [4] = '{6'h20, 6'h22, 6'h24, 6'h25};
  logic [1:0] al_tab [4] = '{2'b00, 2'b01, 2'b10, 2'b11};

  initial begin
    rst_n = 1'b0;
    bus.op = 6'h00; bus.funct = 6'h00; bus.irq = 1'b0;
    cyc(E_ZERO, 2'b00, 1'b0, "reset0");
    cyc(E_ZERO, 2'b00, 1'b0, "reset1");
    rst_n = 1'b1;
    cyc(E_FETCH, 2'b00, 1'b0, "first_fetch");

    run_lw();
    run_rtype(6'h22, 2'b01);
    run_rtype(6'h25, 2'b11);
    run_beq();
    run_addi();
    run_sw();
    run_illegal(6'h3F, 6'h00);
    run_illegal(6'h00, 6'h08);
    run_rtype(6'h20, 2'b00);

    // Reset asserted in MEMWR kills the write strobe on the next cycle.
    bus.op = 6'h2B;
    cyc(E_DECODE, 2'b00, 1'b0, "rst_sw_decode");
    cyc(E_MEMADR, 2'b00, 1'b0, "rst_sw_memadr");
    cyc(E_MEMWR,  2'b00, 1'b0, "rst_sw_memwr");
    rst_n = 1'b0;
    cyc(E_ZERO,   2'b00, 1'b0, "rst_mid_memwr");
    rst_n = 1'b1;
    cyc(E_FETCH,  2'b00, 1'b0, "rst_release_fetch");

    // Interrupt edge during EXEC: instruction completes before any redirect.
    bus.op = 6'h00; bus.funct = 6'h24;
    cyc(E_DECODE, 2'b00, 1'b0, "irq_decode");
    cyc(E_EXEC,   2'b10, 1'b0, "irq_exec");
    bus.irq = 1'b1;
    cyc(E_ALUWB,  2'b00, 1'b0, "irq_aluwb");
`ifdef CONTROL_INTERRUPT_EN
    cyc(E_INTFETCH, 2'b00, 1'b0, "irq_intfetch");
`else
    cyc(E_FETCH,    2'b00, 1'b0, "irq_ignored_fetch");
`endif
    // Level held high must not produce a second acknowledge.
    run_rtype(6'h20, 2'b00);
    run_beq();
    bus.irq = 1'b0;

    // Random mix of legal and illegal instructions.
    for (int i = 0; i < 24; i++) begin
      int k;
      k = $urandom_range(0, 6);
      case (k)
        0: run_lw();
        1: run_sw();
        2: begin
          int j;
          j = $urandom_range(0, 3);
          run_rtype(fn_tab[j], al_tab[j]);
        end
        3: run_beq();
        4: run_addi();
        5: run_illegal(6'h3F, 6'h00);
        default: run_illegal(6'h00, 6'h08);
      endcase
    end

    @(posedge clk);
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
